// File: rtl/riscv_check_pkg.sv
// ============================================================================
//  Module   : riscv_check_pkg
//  Purpose  : Shared types for the riscv run-and-check controller: FSM state
//             encoding, debug-port select codes and the expectation entry.
//             RUN_CHECKER_MASK_EN adds a per-entry compare mask.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_check_pkg;

    localparam int unsigned CHK_XLEN   = 32;
    localparam int unsigned CHK_ADDR_W = 8;

    localparam logic DBG_SEL_REG = 1'b0;
    localparam logic DBG_SEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_CORE = 3'd1,
        ST_RUN      = 3'd2,
        ST_CHK_REQ  = 3'd3,
        ST_CHK_CMP  = 3'd4,
        ST_DONE     = 3'd5
    } chk_state_e;

    typedef struct packed {
        logic                  sel;
        logic [CHK_ADDR_W-1:0] addr;
        logic [CHK_XLEN-1:0]   data;
`ifdef RUN_CHECKER_MASK_EN
        logic [CHK_XLEN-1:0]   mask;
`endif
    } chk_entry_t;

    // A zero mask makes the entry compare as always-equal.
    function automatic logic chk_entry_mismatch(input chk_entry_t e,
                                                input logic [CHK_XLEN-1:0] rd);
`ifdef RUN_CHECKER_MASK_EN
        return |((rd ^ e.data) & e.mask);
`else
        return (rd != e.data);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_halt_detect.sv
// ============================================================================
//  Module   : riscv_halt_detect
//  Purpose  : Run-phase watchdog: counts run cycles, detects a PC that has
//             stopped moving, and flags the cycle budget running out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_halt_detect #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HALT_STABLE = 4,
    parameter int unsigned MAX_CYCLES  = 50,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [XLEN-1:0]  pc,
    output logic             halt,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned c_STB_W = $clog2(HALT_STABLE) + 1;

    logic [XLEN-1:0]    r_prev_pc;
    logic [c_STB_W-1:0] r_stable;
    logic [CNT_W-1:0]   r_cycles;
    logic               w_first;

    // The previous-PC register holds a stale value on the first run cycle.
    assign w_first = (r_cycles == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pc <= '0;
            r_stable  <= '0;
            r_cycles  <= '0;
        end else if (clear) begin
            r_stable  <= '0;
            r_cycles  <= '0;
        end else if (run) begin
            r_cycles  <= r_cycles + 1'b1;
            r_prev_pc <= pc;
            if (w_first || (pc != r_prev_pc)) begin
                r_stable <= '0;
            end else if (!halt) begin
                r_stable <= r_stable + 1'b1;
            end
        end
    end

    assign halt        = run && (r_stable == c_STB_W'(HALT_STABLE - 1));
    assign timeout     = run && !halt && (r_cycles == CNT_W'(MAX_CYCLES - 1));
    assign cycle_count = r_cycles;

endmodule

`default_nettype wire

// File: rtl/riscv_run_checker.sv
// ============================================================================
//  Module   : riscv_run_checker
//  Purpose  : Reset-sequences the riscv core, runs it until halt or timeout,
//             then checks architectural state against an expectation table.
//             Optional build macro: RUN_CHECKER_MASK_EN (per-entry masks).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_run_checker
    import riscv_check_pkg::*;
#(
    parameter int unsigned XLEN         = CHK_XLEN,
    parameter int unsigned ADDR_W       = CHK_ADDR_W,
    parameter int unsigned NUM_CHECKS   = 8,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned HALT_STABLE  = 4,
    parameter int unsigned MAX_CYCLES   = 50,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned c_IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int unsigned c_FC_W      = $clog2(NUM_CHECKS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               core_rst_n,
    input  logic [XLEN-1:0]    pc_i,
    output logic               dbg_rd_en,
    output logic               dbg_rd_sel,
    output logic [ADDR_W-1:0]  dbg_rd_addr,
    input  logic [XLEN-1:0]    dbg_rd_data,
    input  logic               exp_we,
    input  logic [c_IDX_W-1:0] exp_idx,
    input  logic               exp_sel,
    input  logic [ADDR_W-1:0]  exp_addr,
    input  logic [XLEN-1:0]    exp_data,
`ifdef RUN_CHECKER_MASK_EN
    input  logic [XLEN-1:0]    exp_mask,
`endif
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [c_FC_W-1:0]  fail_count,
    output logic [c_IDX_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0]   cycle_count
);

    // Table entry widths come from the package; XLEN/ADDR_W must match them.
    localparam int unsigned c_RST_W = $clog2(RESET_CYCLES + 1);

    chk_state_e          r_state;
    chk_state_e          w_state_nxt;
    chk_entry_t          r_table [NUM_CHECKS];
    chk_entry_t          w_cur;
    chk_entry_t          w_wr_entry;
    logic [c_RST_W-1:0]  r_rst_cnt;
    logic [c_IDX_W-1:0]  r_k;
    logic [c_FC_W-1:0]   r_fail_count;
    logic [c_IDX_W-1:0]  r_first_fail;
    logic                r_timeout;
    logic                w_idle_or_done;
    logic                w_start_acc;
    logic                w_last;
    logic                w_mismatch;
    logic                w_idx_ok;
    logic                w_run;
    logic                w_halt;
    logic                w_time_up;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_acc    = w_idle_or_done && start;
    assign w_run          = (r_state == ST_RUN);
    assign w_cur          = r_table[r_k];
    assign w_last         = (r_k == c_IDX_W'(NUM_CHECKS - 1));
    assign w_mismatch     = chk_entry_mismatch(w_cur, dbg_rd_data);

    generate
        if ((1 << c_IDX_W) > NUM_CHECKS) begin : g_idx_guard
            assign w_idx_ok = (32'(exp_idx) < NUM_CHECKS);
        end else begin : g_idx_full
            assign w_idx_ok = 1'b1;
        end
    endgenerate

    riscv_halt_detect #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE),
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (CNT_W)
    ) u_halt_detect (
        .clk         (clk),
        .rst_n       (reset),
        .clear       (w_start_acc),
        .run         (w_run),
        .pc          (pc_i),
        .halt        (w_halt),
        .timeout     (w_time_up),
        .cycle_count (cycle_count)
    );

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.sel  = exp_sel;
        w_wr_entry.addr = exp_addr;
        w_wr_entry.data = exp_data;
`ifdef RUN_CHECKER_MASK_EN
        w_wr_entry.mask = exp_mask;
`endif
    end

    // The expectation table survives reset so it can be loaded once.
    always_ff @(posedge clk) begin
        if (exp_we && w_idle_or_done && w_idx_ok) begin
            r_table[exp_idx] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = ST_RST_CORE;
            end
            ST_RST_CORE: begin
                if (r_rst_cnt == c_RST_W'(RESET_CYCLES - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt || w_time_up) w_state_nxt = ST_CHK_REQ;
            end
            ST_CHK_REQ: begin
                w_state_nxt = ST_CHK_CMP;
            end
            ST_CHK_CMP: begin
                w_state_nxt = w_last ? ST_DONE : ST_CHK_REQ;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_cnt    <= '0;
            r_k          <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_timeout    <= 1'b0;
        end else if (w_start_acc) begin
            r_rst_cnt    <= '0;
            r_k          <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_CORE: r_rst_cnt <= r_rst_cnt + 1'b1;
                ST_RUN: begin
                    if (w_time_up) r_timeout <= 1'b1;
                end
                ST_CHK_CMP: begin
                    if (w_mismatch) begin
                        r_fail_count <= r_fail_count + 1'b1;
                        if (r_fail_count == '0) r_first_fail <= r_k;
                    end
                    if (!w_last) r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        core_rst_n = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dbg_rd_en  = 1'b0;
        case (r_state)
            ST_RST_CORE: busy = 1'b1;
            ST_RUN, ST_CHK_CMP: begin
                core_rst_n = 1'b1;
                busy       = 1'b1;
            end
            ST_CHK_REQ: begin
                core_rst_n = 1'b1;
                busy       = 1'b1;
                dbg_rd_en  = 1'b1;
            end
            ST_DONE: begin
                core_rst_n = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_rd_sel     = dbg_rd_en ? w_cur.sel  : DBG_SEL_REG;
    assign dbg_rd_addr    = dbg_rd_en ? w_cur.addr : '0;
    assign pass           = done && (r_fail_count == '0) && !r_timeout;
    assign timeout        = r_timeout;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_riscv_run_checker.sv
// ============================================================================
//  Module   : tb_riscv_run_checker
//  Purpose  : Directed bench for riscv_run_checker with a stub core (PC model
//             plus register/memory read port). Macro: RUN_CHECKER_MASK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_run_checker;
    import riscv_check_pkg::*;

    localparam logic [31:0] END_PC = 32'h1C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start_m = 1'b0, start_t = 1'b0;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_idx = '0;
    logic        exp_sel = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
`ifdef RUN_CHECKER_MASK_EN
    logic [31:0] exp_mask = '1;
`endif

    logic        core_rst_n_m, rd_en_m, rd_sel_m, busy_m, done_m, pass_m, timeout_m;
    logic [7:0]  rd_addr_m;
    logic [31:0] pc_m = '0, rd_data_m = '0;
    logic [3:0]  fail_m;
    logic [2:0]  first_m;
    logic [15:0] cyc_m;

    logic        core_rst_n_t, rd_en_t, rd_sel_t, busy_t, done_t, pass_t, timeout_t;
    logic [7:0]  rd_addr_t;
    logic [31:0] pc_t = '0, rd_data_t = '0;
    logic [3:0]  fail_t;
    logic [2:0]  first_t;
    logic [15:0] cyc_t;

    logic [31:0] regs [256];
    logic [31:0] mem  [256];
    int n_rd_m = 0, n_rd_t = 0;
    int errors = 0, checks = 0;

    riscv_run_checker dut (
        .clk(clk), .reset(reset), .start(start_m), .core_rst_n(core_rst_n_m),
        .pc_i(pc_m), .dbg_rd_en(rd_en_m), .dbg_rd_sel(rd_sel_m),
        .dbg_rd_addr(rd_addr_m), .dbg_rd_data(rd_data_m),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_sel(exp_sel),
        .exp_addr(exp_addr), .exp_data(exp_data),
`ifdef RUN_CHECKER_MASK_EN
        .exp_mask(exp_mask),
`endif
        .busy(busy_m), .done(done_m), .pass(pass_m), .timeout(timeout_m),
        .fail_count(fail_m), .first_fail_idx(first_m), .cycle_count(cyc_m)
    );

    riscv_run_checker #(.MAX_CYCLES(8)) dut_to (
        .clk(clk), .reset(reset), .start(start_t), .core_rst_n(core_rst_n_t),
        .pc_i(pc_t), .dbg_rd_en(rd_en_t), .dbg_rd_sel(rd_sel_t),
        .dbg_rd_addr(rd_addr_t), .dbg_rd_data(rd_data_t),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_sel(exp_sel),
        .exp_addr(exp_addr), .exp_data(exp_data),
`ifdef RUN_CHECKER_MASK_EN
        .exp_mask(exp_mask),
`endif
        .busy(busy_t), .done(done_t), .pass(pass_t), .timeout(timeout_t),
        .fail_count(fail_t), .first_fail_idx(first_t), .cycle_count(cyc_t)
    );

    // Stub cores: the main one walks to END_PC and self-loops, the other never halts.
    always @(posedge clk) begin
        if (!core_rst_n_m) pc_m <= '0;
        else if (pc_m != END_PC) pc_m <= pc_m + 32'd4;
        if (!core_rst_n_t) pc_t <= '0;
        else pc_t <= pc_t + 32'd4;
        rd_data_m <= rd_sel_m ? mem[rd_addr_m] : regs[rd_addr_m];
        rd_data_t <= rd_sel_t ? mem[rd_addr_t] : regs[rd_addr_t];
        if (rd_en_m) n_rd_m <= n_rd_m + 1;
        if (rd_en_t) n_rd_t <= n_rd_t + 1;
    end

    task automatic load_exp(input int idx, input logic sel, input int addr,
                            input logic [31:0] data, input logic [31:0] mask);
        exp_we   = 1'b1;
        exp_idx  = idx[2:0];
        exp_sel  = sel;
        exp_addr = addr[7:0];
        exp_data = data;
`ifdef RUN_CHECKER_MASK_EN
        exp_mask = mask;
`else
        if (mask == 32'd0) exp_data = data;
`endif
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic load_all();
        load_exp(0, DBG_SEL_REG, 1, 32'd10,  '1);
        load_exp(1, DBG_SEL_REG, 2, 32'd20,  '1);
        load_exp(2, DBG_SEL_REG, 3, 32'd30,  '1);
        load_exp(3, DBG_SEL_REG, 4, 32'd20,  '1);
        load_exp(4, DBG_SEL_REG, 5, 32'd200, '1);
        load_exp(5, DBG_SEL_REG, 6, 32'd30,  '1);
        load_exp(6, DBG_SEL_REG, 7, 32'd1,   '1);
        load_exp(7, DBG_SEL_MEM, 0, 32'd30,  '1);
    endtask

    task automatic go_main(output bit ok, output int lat);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_m) begin ok = 1'b1; lat = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({core_rst_n_m, busy_m, done_m, pass_m, timeout_m, rd_en_m} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {core_rst_n_m, busy_m, done_m, pass_m, timeout_m, rd_en_m});
        end
        checks++;
        if (fail_m !== 4'd0 || first_m !== 3'd0) begin
            errors++; $display("FAIL reset_fail: got %0d/%0d expected 0/0", fail_m, first_m);
        end
        checks++;
        if (cyc_m !== 16'd0) begin
            errors++; $display("FAIL reset_cycles: got %0d expected 0", cyc_m);
        end
        reset = 1'b1;
        @(negedge clk);
        load_all();
    endtask

    task automatic test_reset_seq();
        bit ok; int lat;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        checks++;
        if ({core_rst_n_m, busy_m, done_m} !== 3'b010) begin
            errors++; $display("FAIL seq_rst0: got %b expected 010", {core_rst_n_m, busy_m, done_m});
        end
        @(negedge clk);
        checks++;
        if (core_rst_n_m !== 1'b0) begin
            errors++; $display("FAIL seq_rst1: got %b expected 0", core_rst_n_m);
        end
        @(negedge clk);
        checks++;
        if (core_rst_n_m !== 1'b1) begin
            errors++; $display("FAIL seq_run: got %b expected 1", core_rst_n_m);
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_m) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL seq_done: got 0 expected 1"); end
    endtask

    task automatic test_pass();
        bit ok; int lat; int rd0;
        rd0 = n_rd_m;
        go_main(ok, lat);
        checks++;
        if (!ok || pass_m !== 1'b1 || busy_m !== 1'b0) begin
            errors++; $display("FAIL pass_flags: got done=%b pass=%b busy=%b expected 1 1 0", done_m, pass_m, busy_m);
        end
        checks++;
        if (fail_m !== 4'd0 || timeout_m !== 1'b0) begin
            errors++; $display("FAIL pass_fail: got %0d/%b expected 0/0", fail_m, timeout_m);
        end
        checks++;
        if (cyc_m !== 16'd12) begin
            errors++; $display("FAIL pass_cycles: got %0d expected 12", cyc_m);
        end
        checks++;
        if (lat !== 30) begin
            errors++; $display("FAIL pass_latency: got %0d expected 30", lat);
        end
        checks++;
        if (n_rd_m - rd0 !== 8) begin
            errors++; $display("FAIL pass_reads: got %0d expected 8", n_rd_m - rd0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_m !== 1'b1 || pass_m !== 1'b1 || core_rst_n_m !== 1'b1) begin
            errors++; $display("FAIL pass_hold: got %b%b%b expected 111", done_m, pass_m, core_rst_n_m);
        end
    endtask

    task automatic test_single_mismatch();
        bit ok; int lat;
        load_exp(4, DBG_SEL_REG, 5, 32'd201, '1);
        go_main(ok, lat);
        checks++;
        if (!ok || pass_m !== 1'b0) begin
            errors++; $display("FAIL single_pass: got done=%b pass=%b expected 1 0", done_m, pass_m);
        end
        checks++;
        if (fail_m !== 4'd1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", fail_m);
        end
        checks++;
        if (first_m !== 3'd4) begin
            errors++; $display("FAIL single_first: got %0d expected 4", first_m);
        end
        load_exp(4, DBG_SEL_REG, 5, 32'd200, '1);
    endtask

    task automatic test_multi_mismatch();
        bit ok; int lat;
        load_exp(2, DBG_SEL_REG, 3, 32'd31, '1);
        load_exp(6, DBG_SEL_REG, 7, 32'd0,  '1);
        go_main(ok, lat);
        checks++;
        if (!ok || fail_m !== 4'd2) begin
            errors++; $display("FAIL multi_count: got %0d expected 2", fail_m);
        end
        checks++;
        if (first_m !== 3'd2 || pass_m !== 1'b0) begin
            errors++; $display("FAIL multi_first: got %0d pass=%b expected 2 pass=0", first_m, pass_m);
        end
        load_exp(2, DBG_SEL_REG, 3, 32'd30, '1);
        load_exp(6, DBG_SEL_REG, 7, 32'd1,  '1);
    endtask

    task automatic test_busy_write();
        bit ok;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (3) @(negedge clk);
        load_exp(0, DBG_SEL_REG, 1, 32'd99, '1);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_m) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || pass_m !== 1'b1 || fail_m !== 4'd0) begin
            errors++; $display("FAIL busy_write: got pass=%b fails=%0d expected 1 0", pass_m, fail_m);
        end
        load_exp(0, DBG_SEL_REG, 1, 32'd10, '1);
    endtask

    task automatic test_timeout();
        bit ok; int rd0;
        rd0 = n_rd_t;
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_t) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || timeout_t !== 1'b1 || pass_t !== 1'b0) begin
            errors++; $display("FAIL to_flags: got done=%b timeout=%b pass=%b expected 1 1 0", done_t, timeout_t, pass_t);
        end
        checks++;
        if (cyc_t !== 16'd8) begin
            errors++; $display("FAIL to_cycles: got %0d expected 8", cyc_t);
        end
        checks++;
        if (n_rd_t - rd0 !== 8 || fail_t !== 4'd0) begin
            errors++; $display("FAIL to_checks: got reads=%0d fails=%0d expected 8 0", n_rd_t - rd0, fail_t);
        end
    endtask

    task automatic test_abort_restart();
        bit ok;
        logic [15:0] c0;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int i = 0; i < 20 && !core_rst_n_m; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({core_rst_n_m, busy_m, done_m, pass_m} !== 4'b0) begin
            errors++; $display("FAIL abort_ctrl: got %b expected 0000", {core_rst_n_m, busy_m, done_m, pass_m});
        end
        checks++;
        if (cyc_m !== 16'd0 || fail_m !== 4'd0) begin
            errors++; $display("FAIL abort_result: got %0d/%0d expected 0/0", cyc_m, fail_m);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int i = 0; i < 20 && !core_rst_n_m; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        c0 = cyc_m;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        checks++;
        if (cyc_m !== c0 + 16'd1 || busy_m !== 1'b1) begin
            errors++; $display("FAIL restart_ignored: got %0d busy=%b expected %0d busy=1", cyc_m, busy_m, c0 + 16'd1);
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_m) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || cyc_m !== 16'd12 || pass_m !== 1'b1) begin
            errors++; $display("FAIL restart_run: got cycles=%0d pass=%b expected 12 1", cyc_m, pass_m);
        end
    endtask

`ifdef RUN_CHECKER_MASK_EN
    task automatic test_mask();
        bit ok; int lat;
        load_exp(4, DBG_SEL_REG, 5, 32'hC9, 32'hF0);
        go_main(ok, lat);
        checks++;
        if (!ok || pass_m !== 1'b1) begin
            errors++; $display("FAIL mask_pass: got %b expected 1", pass_m);
        end
        load_exp(4, DBG_SEL_REG, 5, 32'h0D, 32'hF0);
        go_main(ok, lat);
        checks++;
        if (fail_m !== 4'd1 || first_m !== 3'd4) begin
            errors++; $display("FAIL mask_fail: got %0d/%0d expected 1/4", fail_m, first_m);
        end
        load_exp(4, DBG_SEL_REG, 5, 32'd200, '1);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            regs[i] = '0;
            mem[i]  = '0;
        end
        regs[1] = 32'd10;  regs[2] = 32'd20; regs[3] = 32'd30; regs[4] = 32'd20;
        regs[5] = 32'd200; regs[6] = 32'd30; regs[7] = 32'd1;
        mem[0]  = 32'd30;

        test_reset();
        test_reset_seq();
        test_pass();
        test_single_mismatch();
        test_multi_mismatch();
        test_busy_write();
        test_timeout();
        test_abort_restart();
`ifdef RUN_CHECKER_MASK_EN
        test_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_run_checker.md
Name: riscv_run_checker

Overview:
- Synthesizable, parametrised run-and-check controller for the riscv_processor core. Replaces a fixed-delay testbench run with a handshaked sequence: reset sequencing, bounded run, halt detection, then register/memory signature check.
- Sits beside the core. It drives the core reset, watches the PC, and reads architectural state through a debug read port. It reports pass/fail, mismatch count, first failing entry and cycle count.

Parameters:
- XLEN, 32, data/PC width.
- ADDR_W, 8, debug read address width (register index or data-memory word index).
- NUM_CHECKS, 8, expectation-table depth (1..64).
- RESET_CYCLES, 2, cycles the core is held in reset after start.
- HALT_STABLE, 4, consecutive cycles of unchanged PC that count as halt.
- MAX_CYCLES, 50, run-cycle budget before timeout.
- CNT_W, 16, cycle-counter width; must hold MAX_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- core_rst_n  out  1  active-low reset to the core
- pc_i  in  XLEN  core PC
- dbg_rd_en  out  1  debug read strobe
- dbg_rd_sel  out  1  0 = register file, 1 = data memory
- dbg_rd_addr  out  ADDR_W  debug read address
- dbg_rd_data  in  XLEN  read data, valid the cycle after dbg_rd_en
- exp_we  in  1  expectation-table write strobe
- exp_idx  in  $clog2(NUM_CHECKS)  table entry index
- exp_sel  in  1  entry target (reg/mem)
- exp_addr  in  ADDR_W  entry address
- exp_data  in  XLEN  expected value
- busy  out  1  high from start accept until DONE
- done  out  1  high in DONE state
- pass  out  1  done, no mismatch, no timeout
- timeout  out  1  run ended on MAX_CYCLES
- fail_count  out  $clog2(NUM_CHECKS+1)  number of mismatching entries
- first_fail_idx  out  $clog2(NUM_CHECKS)  index of the lowest failing entry
- cycle_count  out  CNT_W  run cycles elapsed

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; core_rst_n=0.
  - All other outputs are 0. The expectation table is not cleared.
- FSM states: IDLE, RST_CORE, RUN, CHK_REQ, CHK_CMP, DONE.
- IDLE/DONE:
  - core_rst_n=0 in IDLE; core_rst_n=1 in DONE, with the core left running.
  - start moves to RST_CORE. It clears cycle_count, fail_count, first_fail_idx, timeout and pass, and sets busy=1, done=0.
- RST_CORE:
  - core_rst_n=0 for exactly RESET_CYCLES cycles, then RUN. core_rst_n rises on the RUN entry edge.
- RUN:
  - cycle_count increments each cycle.
  - Stable counter: cleared when pc_i differs from the previous-cycle PC, incremented otherwise.
  - Halt: stable counter reaches HALT_STABLE-1 → CHK_REQ.
  - Timeout: cycle_count reaches MAX_CYCLES-1 → timeout=1 and go to CHK_REQ.
  - If halt and timeout occur in the same cycle, halt wins and timeout=0.
  - The first RUN cycle never counts as stable.
- CHK_REQ:
  - dbg_rd_en=1, with sel/addr taken from table entry k (k starts at 0). Next state CHK_CMP.
- CHK_CMP:
  - Compare dbg_rd_data against exp_data[k].
  - On mismatch: fail_count++. If this is the first mismatch, first_fail_idx=k.
  - If k==NUM_CHECKS-1, go to DONE; otherwise k++ and go to CHK_REQ.
  - Latency is 2 cycles per entry.
- Entering DONE: done=1, busy=0, pass=(fail_count==0 && !timeout). Outputs hold until the next start.
- exp_we:
  - Ignored while busy.
  - In IDLE/DONE, writes the entry at the posedge.
  - Out-of-range exp_idx is ignored.
- start while busy is ignored.
- Asynchronous reset mid-run aborts immediately: the core is held in reset and no partial result is reported.

Optional Feature:
- Macro: RUN_CHECKER_MASK_EN.
- Defined:
  - Adds input exp_mask [XLEN] and a per-entry mask in the table.
  - Compare is ((dbg_rd_data ^ exp_data) & mask) != 0.
  - An entry with mask 0 always passes.
- Undefined: full-width equality; no exp_mask port.

Decomposition:
- Package riscv_check_pkg holds:
  - FSM state enum.
  - DBG_SEL_REG/DBG_SEL_MEM constants.
  - Expectation-entry struct {sel, addr, data[, mask]}.
- One sub-module, riscv_halt_detect: PC-stable counter plus timeout counter. It emits halt, timeout and cycle_count.
- Table and compare logic stay in the top.

Test Plan:
- Pass case:
  - Stimulus: load x1=10, x2=20, x3=30, x4=20, x5=200, x6=30, x7=1, mem[0]=30; start; the program ends in a self-loop.
  - Required: done=1, pass=1, fail_count=0, timeout=0, cycle_count < 50.
- Single mismatch:
  - Stimulus: change entry 4 to x5=201.
  - Required: pass=0, fail_count=1, first_fail_idx=4.
- Multiple mismatches:
  - Stimulus: corrupt entries 2 and 6.
  - Required: fail_count=2, first_fail_idx=2.
- Timeout:
  - Stimulus: MAX_CYCLES=8 with a non-halting PC.
  - Required: timeout=1, pass=0, cycle_count=8, and all 8 checks still performed.
- Abort and restart:
  - Stimulus: reset low during RUN, then start pulses while busy.
  - Required: the reset forces core_rst_n=0 and busy=0 within the same cycle; extra start pulses while busy do not restart the cycle count.
- Mask (RUN_CHECKER_MASK_EN):
  - Stimulus: exp x5=0xC9 with mask 0xF0 against actual 200 (0xC8).
  - Required: pass=1.
